// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding and counter widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned XFER_CNT_W = 16;
  localparam int unsigned WAIT_W     = 3;

endpackage

// File: rtl/apb_wait_ctr.sv
// Access-phase wait-state counter: loaded on SETUP entry, counts down to zero.
module apb_wait_ctr
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= WAIT_W'(WAIT_CYCLES);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_reg_bank.sv
// APB slave register bank with configurable wait states, address reflection
// on out-of-range reads, error on out-of-range writes and a transfer counter.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 5,
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         DEPTH       = 16,
  parameter int unsigned         WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [DEPTH*DATA_W-1:0]   reg_q,
  output logic [XFER_CNT_W-1:0]     xfer_count
);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("apb_reg_bank: DEPTH must be in 1..2**ADDR_W");
  end
  if (WAIT_CYCLES > 7) begin : g_bad_wait
    $error("apb_reg_bank: WAIT_CYCLES must be in 0..7");
  end

  apb_state_e        state;
  logic              wait_zero;
  logic              acc_phase;
  logic              addr_hit;
  logic              missing_setup;
  logic              access_done;
  logic              enter_setup;
  logic              wait_dec;
  logic              wr_en;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] regs [DEPTH];

  assign acc_phase     = psel & penable;
  assign addr_hit      = (32'(paddr) < DEPTH);
  // pready is combinational, so it is masked while reset is held.
  assign missing_setup = rst_n & (state == IDLE) & acc_phase;
  assign access_done   = rst_n & (state == ACCESS) & acc_phase & wait_zero;
  assign enter_setup   = (state == IDLE) & psel & ~penable;
  assign wait_dec      = (state == ACCESS) & acc_phase & ~wait_zero;
  assign wr_en         = access_done & pwrite & addr_hit;

  assign pready  = missing_setup | access_done;
  assign pslverr = missing_setup | (access_done & pwrite & ~addr_hit);

  apb_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (enter_setup),
    .dec   (wait_dec),
    .zero  (wait_zero)
  );

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(paddr) == i) rd_sel = regs[i];
    end
  end

  always_comb begin
    prdata = '0;
    if (access_done && !pwrite) begin
      prdata = addr_hit ? rd_sel : DATA_W'(paddr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enter_setup) state <= SETUP;
        SETUP:   state <= psel ? ACCESS : IDLE;
        // A completing cycle always has penable=1, so the next setup is
        // recognised from IDLE on the following cycle.
        ACCESS:  if (!psel || access_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (32'(paddr) == i) regs[i] <= pwdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (pready && xfer_count != '1) begin
      xfer_count <= xfer_count + XFER_CNT_W'(1);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Randomised APB bench for apb_reg_bank with two instances (2 and 0 wait states).
module tb_apb_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel    [2];
  logic         penable [2];
  logic         pwrite  [2];
  logic [4:0]   paddr   [2];
  logic [7:0]   pwdata  [2];
  logic [7:0]   prdata  [2];
  logic         pready  [2];
  logic         pslverr [2];
  logic [127:0] reg_q   [2];
  logic [15:0]  xfer_count [2];

  int           errors = 0;
  int           checks = 0;

  logic [7:0]   mdl  [2][16];
  int           mcnt [2];
  int           wcfg [2] = '{2, 0};

  always #5 clk = ~clk;

  apb_reg_bank #(
    .ADDR_W (5), .DATA_W (8), .DEPTH (16), .WAIT_CYCLES (2), .RESET_VAL (8'h00)
  ) u_dut_w2 (
    .clk (clk), .rst_n (rst_n), .psel (psel[0]), .penable (penable[0]),
    .pwrite (pwrite[0]), .paddr (paddr[0]), .pwdata (pwdata[0]),
    .prdata (prdata[0]), .pready (pready[0]), .pslverr (pslverr[0]),
    .reg_q (reg_q[0]), .xfer_count (xfer_count[0])
  );

  apb_reg_bank #(
    .ADDR_W (5), .DATA_W (8), .DEPTH (16), .WAIT_CYCLES (0), .RESET_VAL (8'h00)
  ) u_dut_w0 (
    .clk (clk), .rst_n (rst_n), .psel (psel[1]), .penable (penable[1]),
    .pwrite (pwrite[1]), .paddr (paddr[1]), .pwdata (pwdata[1]),
    .prdata (prdata[1]), .pready (pready[1]), .pslverr (pslverr[1]),
    .reg_q (reg_q[1]), .xfer_count (xfer_count[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mdl_flat(input int d);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = mdl[d][i];
    return f;
  endfunction

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mdl[d][i] = 8'h00;
      mcnt[d] = 0;
    end
  endtask

  task automatic check_state(input int d, input string tag);
    check({tag, "_reg_q"}, reg_q[d], mdl_flat(d));
    check({tag, "_count"}, 128'(xfer_count[d]), 128'(mcnt[d]));
  endtask

  // Full transfer; entered and left just after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [4:0] addr,
                      input logic [7:0] data, input bit jitter);
    int         waits = 0;
    bit         done = 0;
    logic [7:0] exp_rd;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (pready[d]) begin
        exp_rd = (wr) ? 8'h00 : ((addr < 16) ? mdl[d][addr[3:0]] : {3'b000, addr});
        check("waits", 128'(waits), 128'(wcfg[d] + 1));
        check("pslverr", 128'(pslverr[d]), 128'(wr && addr >= 16));
        check("prdata", 128'(prdata[d]), 128'(exp_rd));
        if (wr && addr < 16) mdl[d][addr[3:0]] = pwdata[d];
        if (mcnt[d] < 65535) mcnt[d]++;
        done = 1;
      end else begin
        check("wait_out", {pslverr[d], prdata[d]}, '0);
        waits++;
        if (waits > 12) begin
          check("timeout", 128'(waits), 128'(wcfg[d] + 1));
          done = 1;
        end
      end
      @(posedge clk); #1;
      if (!done && jitter && wr) pwdata[d] = 8'($urandom);
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    check_state(d, "xfer");
  endtask

  initial begin
    mdl_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_pready", 128'(pready[d]), 128'(0));
      check_state(d, "rst");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back with two wait states.
    xfer(0, 1'b1, 5'd3, 8'hA5, 1'b0);
    xfer(0, 1'b0, 5'd3, 8'h00, 1'b0);
    check("a5_byte", 128'(reg_q[0][31:24]), 128'(8'hA5));
    check("a5_count", 128'(xfer_count[0]), 128'(2));

    // Out-of-range read reflects the address; out-of-range write errors.
    xfer(0, 1'b0, 5'd20, 8'h00, 1'b0);
    xfer(0, 1'b1, 5'd20, 8'h55, 1'b0);

    // Zero wait states, back-to-back write/read.
    xfer(1, 1'b1, 5'd0, 8'h3C, 1'b0);
    xfer(1, 1'b0, 5'd0, 8'h00, 1'b0);

    // Access phase with no preceding setup.
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 5'd2; pwdata[1] = 8'hEE;
    @(negedge clk);
    check("nosetup_pready", 128'(pready[1]), 128'(1));
    check("nosetup_err", 128'(pslverr[1]), 128'(1));
    check("nosetup_prdata", 128'(prdata[1]), 128'(0));
    if (mcnt[1] < 65535) mcnt[1]++;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    check_state(1, "nosetup");
    xfer(1, 1'b0, 5'd2, 8'h00, 1'b0);

    // Randomised traffic with wdata changing during wait states.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
        xfer(d, 1'($urandom_range(0, 1)), a, 8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
      end
    end

    // Reset during the wait states of a write.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 5'd7; pwdata[0] = 8'h99;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_out", {pready[0], pslverr[0], prdata[0]}, '0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; rst_n = 1'b1;
    mdl_reset();
    check_state(0, "rstmid0");
    check_state(1, "rstmid1");
    @(posedge clk); #1;

    // Abort a write after one wait cycle.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 5'd5; pwdata[0] = 8'h77;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(negedge clk);
    check("abort_w1", 128'(pready[0]), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_w2", 128'(pready[0]), 128'(0));
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    check("abort_w3", 128'(pready[0]), 128'(0));
    @(posedge clk); #1;
    check_state(0, "abort");
    check("abort_reg5", 128'(reg_q[0][47:40]), 128'(8'h00));
    xfer(0, 1'b0, 5'd5, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
